// File: rtl/turn_sequencer.sv
// turn_sequencer: game-flow controller. Runs the initial deal, rotates turns
// around the board ring and picks a random undrawn card for each local draw.
module turn_sequencer #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned PLAYER      = 0,
  parameter int unsigned INIT_DRAW   = 14,
  parameter int unsigned DECK_SIZE   = 106,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int unsigned CW = $clog2(DECK_SIZE),
  localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 interboard_rst,
  input  logic                 start_game,
  input  logic                 done_and_next,
  input  logic                 draw_and_next,
  input  logic [DECK_SIZE-1:0] available_card,
  input  logic                 rx_valid,
  input  logic [3:0]           rx_msg_type,
  input  logic                 tx_ready,
  output logic                 ctrl_en,
  output logic [3:0]           ctrl_msg_type,
  output logic [CW-1:0]        ctrl_card,
  output logic [PW-1:0]        cur_player,
  output logic                 my_turn,
  output logic                 deal_done,
  output logic                 can_draw
);

  localparam int unsigned MW = $clog2(DECK_SIZE + 1);
  localparam int unsigned DW = ($clog2(INIT_DRAW + 1) > 0) ? $clog2(INIT_DRAW + 1) : 1;

  localparam logic [3:0] MSG_DRAW = 4'd4;
  localparam logic [3:0] MSG_TURN = 4'd7;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DEAL      = 3'd1;
  localparam logic [2:0] S_PICK_LOAD = 3'd2;
  localparam logic [2:0] S_PICK_SCAN = 3'd3;
  localparam logic [2:0] S_SEND_DRAW = 3'd4;
  localparam logic [2:0] S_SEND_TURN = 3'd5;
  localparam logic [2:0] S_REMOTE    = 3'd6;
  localparam logic [2:0] S_MY_TURN   = 3'd7;

  logic [2:0]    state, state_d;
  logic [PW-1:0] cur_d;
  logic [DW-1:0] dealt, dealt_d;
  logic          deal_done_d;
  logic [CW-1:0] idx, idx_d;
  logic [MW-1:0] miss, miss_d;
  logic [15:0]   lfsr;

  logic          wrap;
  logic [PW-1:0] cur_adv;
  logic [CW-1:0] idx_raw, idx_load, idx_inc;

  logic          ctrl_en_d;
  logic [3:0]    ctrl_msg_type_d;
  logic [CW-1:0] ctrl_card_d;
  logic          my_turn_d;
  logic          can_draw_d;

  // Random source; free-running, only the hard reset reseeds it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Turn-advance and card-index helpers
  always_comb begin
    wrap     = (cur_player == PW'(NUM_PLAYERS - 1));
    cur_adv  = wrap ? '0 : cur_player + PW'(1);
    idx_raw  = lfsr[CW-1:0];
    idx_load = ({1'b0, idx_raw} >= (CW+1)'(DECK_SIZE))
             ? CW'({1'b0, idx_raw} - (CW+1)'(DECK_SIZE)) : idx_raw;
    idx_inc  = (idx == CW'(DECK_SIZE - 1)) ? '0 : idx + CW'(1);
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state;
    cur_d       = cur_player;
    dealt_d     = dealt;
    deal_done_d = deal_done;
    idx_d       = idx;
    miss_d      = miss;

    case (state)
      S_IDLE: begin
        if (start_game) begin
          state_d     = S_DEAL;
          cur_d       = '0;
          dealt_d     = '0;
          deal_done_d = 1'b0;
        end
      end
      S_DEAL: begin
        if (cur_player == PW'(PLAYER)) begin
          state_d = (dealt >= DW'(INIT_DRAW)) ? S_SEND_TURN : S_PICK_LOAD;
        end else begin
          state_d = S_REMOTE;
        end
      end
      S_REMOTE: begin
        if (rx_valid && (rx_msg_type == MSG_TURN)) begin
          cur_d = cur_adv;
          if (wrap && !deal_done) deal_done_d = 1'b1;
          if (deal_done_d) begin
            state_d = (cur_adv == PW'(PLAYER)) ? S_MY_TURN : S_REMOTE;
          end else begin
            state_d = S_DEAL;
          end
        end
      end
      S_MY_TURN: begin
        if (draw_and_next) begin
          state_d = S_PICK_LOAD;
        end else if (done_and_next) begin
          state_d = S_SEND_TURN;
        end
      end
      S_PICK_LOAD: begin
        idx_d   = idx_load;
        miss_d  = '0;
        state_d = S_PICK_SCAN;
      end
      S_PICK_SCAN: begin
        if (miss == MW'(DECK_SIZE)) begin
          state_d = S_SEND_TURN;
        end else if (available_card[idx]) begin
          state_d = S_SEND_DRAW;
        end else begin
          idx_d  = idx_inc;
          miss_d = miss + MW'(1);
        end
      end
      S_SEND_DRAW: begin
        if (tx_ready) begin
          if (!deal_done) begin
            dealt_d = dealt + DW'(1);
            state_d = S_DEAL;
          end else begin
            state_d = S_SEND_TURN;
          end
        end
      end
      S_SEND_TURN: begin
        if (tx_ready) begin
          cur_d = cur_adv;
          if (wrap && !deal_done) begin
            deal_done_d = 1'b1;
            dealt_d     = '0;
          end
          if (deal_done_d) begin
            state_d = (cur_adv == PW'(PLAYER)) ? S_MY_TURN : S_REMOTE;
          end else begin
            state_d = S_DEAL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Soft reset overrides everything, including an open handshake
    if (interboard_rst) begin
      state_d     = S_IDLE;
      cur_d       = '0;
      dealt_d     = '0;
      deal_done_d = 1'b0;
      idx_d       = '0;
      miss_d      = '0;
    end

    ctrl_en_d       = (state_d == S_SEND_DRAW) || (state_d == S_SEND_TURN);
    ctrl_msg_type_d = (state_d == S_SEND_DRAW) ? MSG_DRAW :
                      (state_d == S_SEND_TURN) ? MSG_TURN : 4'd0;
    ctrl_card_d     = (state_d == S_SEND_DRAW) ? idx_d : '0;
    my_turn_d       = (state_d == S_MY_TURN);
    can_draw_d      = my_turn_d && (|available_card);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cur_player    <= '0;
      dealt         <= '0;
      deal_done     <= 1'b0;
      idx           <= '0;
      miss          <= '0;
      ctrl_en       <= 1'b0;
      ctrl_msg_type <= 4'd0;
      ctrl_card     <= '0;
      my_turn       <= 1'b0;
      can_draw      <= 1'b0;
    end else begin
      state         <= state_d;
      cur_player    <= cur_d;
      dealt         <= dealt_d;
      deal_done     <= deal_done_d;
      idx           <= idx_d;
      miss          <= miss_d;
      ctrl_en       <= ctrl_en_d;
      ctrl_msg_type <= ctrl_msg_type_d;
      ctrl_card     <= ctrl_card_d;
      my_turn       <= my_turn_d;
      can_draw      <= can_draw_d;
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: a 2-player board (player 0) and a
// 3-player board (player 2) driven by separate stimulus.
module tb_turn_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Board A: NUM_PLAYERS=2, PLAYER=0
  logic         a_ibr, a_start, a_done, a_draw, a_rx_valid, a_tx_ready;
  logic [105:0] a_avail;
  logic [3:0]   a_rx_type;
  logic         a_ctrl_en, a_my_turn, a_deal_done, a_can_draw;
  logic [3:0]   a_type;
  logic [6:0]   a_card;
  logic [0:0]   a_cur;

  // Board B: NUM_PLAYERS=3, PLAYER=2
  logic         b_ibr, b_start, b_done, b_draw, b_rx_valid, b_tx_ready;
  logic [105:0] b_avail;
  logic [3:0]   b_rx_type;
  logic         b_ctrl_en, b_my_turn, b_deal_done, b_can_draw;
  logic [3:0]   b_type;
  logic [6:0]   b_card;
  logic [1:0]   b_cur;

  int checks = 0;
  int errors = 0;

  turn_sequencer #(.NUM_PLAYERS(2), .PLAYER(0)) u_dut (
    .clk(clk), .rst(rst), .interboard_rst(a_ibr), .start_game(a_start),
    .done_and_next(a_done), .draw_and_next(a_draw), .available_card(a_avail),
    .rx_valid(a_rx_valid), .rx_msg_type(a_rx_type), .tx_ready(a_tx_ready),
    .ctrl_en(a_ctrl_en), .ctrl_msg_type(a_type), .ctrl_card(a_card),
    .cur_player(a_cur), .my_turn(a_my_turn), .deal_done(a_deal_done),
    .can_draw(a_can_draw)
  );

  turn_sequencer #(.NUM_PLAYERS(3), .PLAYER(2)) u_dut3 (
    .clk(clk), .rst(rst), .interboard_rst(b_ibr), .start_game(b_start),
    .done_and_next(b_done), .draw_and_next(b_draw), .available_card(b_avail),
    .rx_valid(b_rx_valid), .rx_msg_type(b_rx_type), .tx_ready(b_tx_ready),
    .ctrl_en(b_ctrl_en), .ctrl_msg_type(b_type), .ctrl_card(b_card),
    .cur_player(b_cur), .my_turn(b_my_turn), .deal_done(b_deal_done),
    .can_draw(b_can_draw)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_rx(input logic [3:0] t);
    a_rx_valid = 1'b1;
    a_rx_type  = t;
    tick();
    a_rx_valid = 1'b0;
    a_rx_type  = 4'd0;
  endtask

  task automatic b_rx(input logic [3:0] t);
    b_rx_valid = 1'b1;
    b_rx_type  = t;
    tick();
    b_rx_valid = 1'b0;
    b_rx_type  = 4'd0;
  endtask

  task automatic a_wait_req(input int limit, output int n);
    n = 0;
    while (!a_ctrl_en && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int draws;
    bit distinct_ok, got_turn, cd_ok, stable_ok;
    logic [3:0] hold_type;
    logic [6:0] hold_card;

    rst = 1'b0;
    a_ibr = 0; a_start = 0; a_done = 0; a_draw = 0; a_rx_valid = 0; a_rx_type = 0;
    a_tx_ready = 0; a_avail = '1;
    b_ibr = 0; b_start = 0; b_done = 0; b_draw = 0; b_rx_valid = 0; b_rx_type = 0;
    b_tx_ready = 1; b_avail = '1;
    tick(); tick();

    // Reset values
    check("rst_ctrl_en", 32'(a_ctrl_en), 0);
    check("rst_type", 32'(a_type), 0);
    check("rst_card", 32'(a_card), 0);
    check("rst_cur", 32'(a_cur), 0);
    check("rst_my_turn", 32'(a_my_turn), 0);
    check("rst_deal_done", 32'(a_deal_done), 0);
    check("rst_can_draw", 32'(a_can_draw), 0);
    rst = 1'b1;
    tick();

    // Deal on board A: 14 distinct HAND_DRAWs then STATE_TURN
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    draws = 0; distinct_ok = 1; got_turn = 0;
    for (int c = 0; c < 3000 && !got_turn; c++) begin
      tick();
      a_tx_ready = a_ctrl_en;
      if (a_ctrl_en) begin
        if (a_type == 4'd4) begin
          if (a_card >= 7'd106) distinct_ok = 0;
          else begin
            if (!a_avail[a_card]) distinct_ok = 0;
            a_avail[a_card] = 1'b0;
          end
          draws++;
        end else if (a_type == 4'd7) begin
          got_turn = 1;
        end
      end
    end
    check("deal_turn_msg", 32'(got_turn), 1);
    check("deal_draws", 32'(draws), 14);
    check("deal_distinct", 32'(distinct_ok), 1);
    tick();
    a_tx_ready = 1'b0;
    check("deal_cur_after_send", 32'(a_cur), 1);
    check("deal_done_early", 32'(a_deal_done), 0);
    tick();
    a_rx(4'd7);
    check("deal_done_set", 32'(a_deal_done), 1);
    check("deal_my_turn", 32'(a_my_turn), 1);
    check("deal_cur_wrap", 32'(a_cur), 0);
    check("deal_can_draw", 32'(a_can_draw), 1);

    // Single card at index 57
    a_avail = '0;
    a_avail[57] = 1'b1;
    a_draw = 1'b1;
    tick();
    a_draw = 1'b0;
    a_wait_req(300, n);
    check("one_req", 32'(a_ctrl_en), 1);
    check("one_type", 32'(a_type), 4);
    check("one_card", 32'(a_card), 57);
    a_tx_ready = 1'b1;
    tick();
    check("one_turn_en", 32'(a_ctrl_en), 1);
    check("one_turn_type", 32'(a_type), 7);
    check("one_turn_card", 32'(a_card), 0);
    tick();
    a_tx_ready = 1'b0;
    check("one_en_drop", 32'(a_ctrl_en), 0);
    check("one_cur", 32'(a_cur), 1);
    check("one_my_turn", 32'(a_my_turn), 0);
    a_avail = '0;
    a_rx(4'd7);
    check("one_back", 32'(a_my_turn), 1);

    // Empty deck: STATE_TURN exactly 2+106 edges after the draw is sampled
    check("empty_can_draw_start", 32'(a_can_draw), 0);
    a_draw = 1'b1;
    tick();
    a_draw = 1'b0;
    n = 0; cd_ok = 1;
    while (!a_ctrl_en && n < 300) begin
      tick();
      n++;
      if (a_can_draw !== 1'b0) cd_ok = 0;
    end
    check("empty_latency", 32'(n), 108);
    check("empty_type", 32'(a_type), 7);
    check("empty_can_draw", 32'(cd_ok), 1);
    a_tx_ready = 1'b1;
    tick();
    a_tx_ready = 1'b0;
    check("empty_cur", 32'(a_cur), 1);
    a_avail = '1;
    a_rx(4'd7);
    check("empty_back", 32'(a_my_turn), 1);

    // Both buttons: draw wins; request stable while tx_ready low
    a_draw = 1'b1;
    a_done = 1'b1;
    tick();
    a_draw = 1'b0;
    a_done = 1'b0;
    a_wait_req(300, n);
    check("both_req", 32'(a_ctrl_en), 1);
    check("both_type", 32'(a_type), 4);
    hold_type = a_type;
    hold_card = a_card;
    stable_ok = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (a_ctrl_en !== 1'b1 || a_type !== hold_type || a_card !== hold_card) stable_ok = 0;
    end
    check("both_stable", 32'(stable_ok), 1);
    a_tx_ready = 1'b1;
    tick();
    check("both_then_turn", 32'(a_type), 7);
    tick();
    a_tx_ready = 1'b0;
    check("both_cur", 32'(a_cur), 1);
    a_rx(4'd7);
    check("both_back", 32'(a_my_turn), 1);

    // interboard_rst during SEND_DRAW
    a_draw = 1'b1;
    tick();
    a_draw = 1'b0;
    a_wait_req(300, n);
    check("ibr_in_send", 32'(a_type), 4);
    a_ibr = 1'b1;
    tick();
    a_ibr = 1'b0;
    check("ibr_ctrl_en", 32'(a_ctrl_en), 0);
    check("ibr_type", 32'(a_type), 0);
    check("ibr_cur", 32'(a_cur), 0);
    check("ibr_deal_done", 32'(a_deal_done), 0);
    check("ibr_my_turn", 32'(a_my_turn), 0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_wait_req(300, n);
    check("ibr_restart_req", 32'(a_ctrl_en), 1);
    check("ibr_restart_type", 32'(a_type), 4);
    check("ibr_restart_deal", 32'(a_deal_done), 0);

    // Board B: 3 players, this board is player 2
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    check("b_cur0", 32'(b_cur), 0);
    b_rx(4'd7);
    tick();
    check("b_cur1", 32'(b_cur), 1);
    check("b_deal_open", 32'(b_deal_done), 0);
    b_rx(4'd7);
    n = 0;
    while (!b_deal_done && n < 3000) begin
      tick();
      n++;
    end
    check("b_deal_done", 32'(b_deal_done), 1);
    check("b_cur_wrapped", 32'(b_cur), 0);
    check("b_not_my_turn", 32'(b_my_turn), 0);
    b_rx(4'd4);
    check("b_type4_ignored", 32'(b_cur), 0);
    b_rx(4'd7);
    check("b_cur_play1", 32'(b_cur), 1);
    check("b_still_remote", 32'(b_my_turn), 0);
    b_rx(4'd7);
    check("b_cur_play2", 32'(b_cur), 2);
    check("b_my_turn", 32'(b_my_turn), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Parametrised game-flow controller for an N-player board game: runs the initial deal, rotates turns across NUM_PLAYERS boards, and picks a random undrawn card from the shared deck for each local draw. Sits between the player-input logic (done/draw buttons), deck memory (`available_card`) and the interboard link. It emits HAND_DRAW and STATE_TURN messages and consumes remote STATE_TURN messages to keep `cur_player` identical on every board.

## Interface
- NUM_PLAYERS, 2: boards in the ring, 2..4.
- PLAYER, 0: this board's index, 0..NUM_PLAYERS-1.
- INIT_DRAW, 14: cards each player draws during the deal.
- DECK_SIZE, 106: deck entries; CW = $clog2(DECK_SIZE).
- LFSR_SEED, 16'hACE1: nonzero LFSR reset value.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- interboard_rst  in  1  synchronous soft reset, active-high.
- start_game  in  1  one-cycle pulse, honoured only in IDLE.
- done_and_next  in  1  one-cycle pulse: end turn without drawing.
- draw_and_next  in  1  one-cycle pulse: draw one card, then end turn.
- available_card  in  DECK_SIZE  bit i = 1 if deck entry i is still undrawn.
- rx_valid  in  1  remote message strobe.
- rx_msg_type  in  4  remote message type.
- tx_ready  in  1  interboard link accepted the current message.
- ctrl_en  out  1  message request, level-held until accepted.
- ctrl_msg_type  out  4  4 = HAND_DRAW, 7 = STATE_TURN.
- ctrl_card  out  CW  deck index for HAND_DRAW; 0 otherwise.
- cur_player  out  max(1,$clog2(NUM_PLAYERS))  index of the player whose turn it is.
- my_turn  out  1  high in MY_TURN.
- deal_done  out  1  high once the deal phase has completed.
- can_draw  out  1  high when state is MY_TURN and |available_card.

## Operation
- States: IDLE, DEAL, PICK_LOAD, PICK_SCAN, SEND_DRAW, SEND_TURN, REMOTE, MY_TURN.
- IDLE + start_game -> DEAL. cur_player = 0, dealt = 0.
- DEAL:
  - If cur_player == PLAYER and dealt < INIT_DRAW -> PICK_LOAD.
  - If cur_player == PLAYER and dealt == INIT_DRAW -> SEND_TURN.
  - Otherwise -> REMOTE.
- REMOTE: on rx_valid and rx_msg_type == 7, advance cur_player (wrap NUM_PLAYERS-1 -> 0). Other message types are ignored.
  - If the advance wraps during the deal, set deal_done.
  - Next state: deal_done ? (cur_player == PLAYER ? MY_TURN : REMOTE) : DEAL.
- MY_TURN:
  - draw_and_next -> PICK_LOAD.
  - done_and_next -> SEND_TURN.
  - Both asserted in the same cycle: draw wins.
- PICK_LOAD: idx = lfsr[CW-1:0]; if idx >= DECK_SIZE, subtract DECK_SIZE once. Clear the miss counter.
- PICK_SCAN: test available_card[idx] each cycle.
  - Hit -> SEND_DRAW with ctrl_card = idx.
  - Miss -> idx+1, wrapping DECK_SIZE-1 -> 0; count the miss.
  - After DECK_SIZE misses (deck empty) -> SEND_TURN. During the deal, any remaining deal draws are skipped.
- SEND_DRAW: ctrl_en = 1, type 4. On tx_ready:
  - Deal phase: dealt+1, -> DEAL.
  - Play phase: -> SEND_TURN.
- SEND_TURN: ctrl_en = 1, type 7. On tx_ready:
  - Advance cur_player. If the advance wraps during the deal, set deal_done and clear dealt.
  - Next state as in REMOTE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every cycle in every state. Reset only by rst, never by interboard_rst.
- rx messages arriving while in local states (PICK_*, SEND_*, MY_TURN) are dropped.

## Timing
- rst low: state IDLE, all outputs 0, cur_player 0, deal_done 0, dealt 0, lfsr = LFSR_SEED.
- interboard_rst: same as rst on the next edge, except the LFSR keeps running. It overrides all other inputs, including mid-handshake; ctrl_en falls the next cycle.
- start_game -> DEAL at edge 1. Decision at edge 2.
- draw_and_next -> ctrl_en (type 4) after 2 + m cycles, where m is the number of misses. m ≤ DECK_SIZE.
- ctrl_en, ctrl_msg_type and ctrl_card are registered and stable until the cycle tx_ready = 1. They drop, or change to the next message, on the following edge.
- Memory must clear the drawn bit of available_card by the cycle after tx_ready; the next PICK_LOAD starts no earlier than that cycle.
- tx_ready outside the SEND states is ignored.

## Test plan
- Deal, NUM_PLAYERS = 2, PLAYER = 0, available_card = all ones -> 14 HAND_DRAW messages with distinct ctrl_card values, then STATE_TURN. cur_player = 1. After remote type 7: deal_done = 1, my_turn = 1.
- Single card: available_card has only bit 57 set, draw_and_next -> ctrl_card = 57, type 4, then type 7. cur_player advances.
- Empty deck: available_card = 0, draw_and_next -> no HAND_DRAW; type 7 is sent exactly 2 + 106 cycles later. can_draw = 0 throughout.
- NUM_PLAYERS = 3, PLAYER = 2, play phase: two remote type-7 messages move cur_player 0 -> 1 -> 2, my_turn = 1. A type-4 message does not advance cur_player.
- done_and_next and draw_and_next in the same cycle -> HAND_DRAW is issued first. tx_ready held low for 20 cycles keeps ctrl_en, ctrl_card and ctrl_msg_type constant.
- interboard_rst pulsed during SEND_DRAW -> IDLE next cycle, ctrl_en = 0, cur_player = 0, deal_done = 0. A following start_game restarts the deal.
